sim_quad_encoder: RTL
=====================

# sim_quad_encoder

Quadrature wheel-encoder emulator for the HIL rig, placed directly downstream of the 200 kHz simulation clock divider. It samples the divided simulation clock as data in the 50 MHz domain and turns each rising edge into a one-cycle sim tick. On each tick a signed velocity is added into a phase accumulator, and every accumulator carry or borrow steps a position counter and the A/B quadrature outputs fed to the pod under test.

## Interface
Parameters:
- ACC_W, 16, phase accumulator width; one position step per 2^ACC_W accumulated velocity
- VEL_W, 16, velocity width, signed two's complement; must be ≤ ACC_W
- POS_W, 32, position counter width, signed
- IDX_SHIFT, 10, index period is 2^IDX_SHIFT counts (used only with SIM_ENC_INDEX_EN)

Ports:
- clk_50Mhz  in  1  system clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- clk_200khz  in  1  divided simulation clock from the divider, treated as data
- enable  in  1  1 = accumulate on ticks; 0 = freeze acc/position
- velocity  in  VEL_W  signed increment per tick, sampled in the step cycle
- load_valid  in  1  one-cycle position preset strobe
- load_pos  in  POS_W  preset value
- tick  out  1  one-cycle pulse per simulation clock rising edge
- position  out  POS_W  signed emulated count
- quad_a  out  1  encoder channel A
- quad_b  out  1  encoder channel B
- wrap  out  1  sticky: position wrapped past signed max/min
- index  out  1  only with SIM_ENC_INDEX_EN

## Operation
- Synchroniser: sync1 ← clk_200khz, sync2 ← sync1, prev ← sync2. tick_int = sync2 & ~prev.
- On tick_int: the registered tick goes high for one cycle. If enable=1, compute sum = acc + sign-extend(velocity) in ACC_W+1 bits:
  - velocity ≥ 0 and carry out gives position +1.
  - velocity < 0 and no carry (borrow) gives position −1.
  - acc ← sum[ACC_W-1:0].
- At most one step per tick, because |velocity| < 2^ACC_W.
- Quadrature state is q = position[1:0]. quad_a = q[1], quad_b = q[1]^q[0].
  - Forward sequence (AB): 00→01→11→10→00.
  - Reverse is the mirror of that sequence.
- wrap: set when +1 is applied at 2^(POS_W-1)−1, or −1 at −2^(POS_W-1). Position wraps modulo 2^POS_W. wrap is cleared only by load_valid or reset.
- load_valid: position ← load_pos, acc ← 0, wrap ← 0. Load has priority over a coincident tick_int; that cycle's step is discarded, but tick still pulses.
- enable=0: ticks still pulse; acc, position and quad outputs hold.

## Timing
- Reset values: tick=0, position=0, quad_a=0, quad_b=0, wrap=0, index=1 (position 0), acc=0, sync regs=0.
- clk_200khz first sampled high at edge k gives tick high after edge k+2, for exactly one cycle.
- position, quad_a/quad_b and wrap update on the same edge that asserts tick, so they are coherent with tick.
- load_valid at edge j gives the new position after edge j.
- Reset asserted mid-run clears all state at the next edge. The first tick after release requires a fresh 0→1 on sync2.
- A clk_200khz level held high gives exactly one tick.

## Configuration
- SIM_ENC_INDEX_EN defined: the index port exists. It is registered and high while position[IDX_SHIFT-1:0]==0, updating with position.
- SIM_ENC_INDEX_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with clk_200khz toggling → position=0, AB=00, tick=0, wrap=0. Release; the first tick appears 3 edges after the next rising clk_200khz.
- Forward: velocity=16384, enable=1, 8 ticks → position 1 after tick 4 (AB=01), 2 after tick 8 (AB=11); tick period 250 cycles.
- Reverse: after reset, velocity=−16384 → position −1 on tick 1 (AB=10), −2 on tick 5 (AB=11).
- Wrap: load_pos=32'h7FFFFFFF, velocity=32767 → on tick 3 position=32'h80000000, wrap=1, AB 10→00. A subsequent load_valid clears wrap.
- Collision: load_valid with load_pos=100 in the tick_int cycle, velocity=32767, acc near carry → position=100, acc=0, tick still pulses.
- Freeze: enable=0, velocity=32767, 10 ticks → 10 tick pulses, position and AB unchanged. With SIM_ENC_INDEX_EN: stepping from 1023 to 1024 raises index.

Source files
------------

// File: rtl/sim_quad_encoder.sv
// rtl/sim_quad_encoder.sv - quadrature wheel-encoder emulator stepped by the divided simulation clock
// Optional index output is built when SIM_ENC_INDEX_EN is defined.
module sim_quad_encoder #(
  parameter int ACC_W     = 16,
  parameter int VEL_W     = 16,
  parameter int POS_W     = 32,
  parameter int IDX_SHIFT = 10
) (
  input  logic                    clk_50Mhz,
  input  logic                    rst_n,
  input  logic                    clk_200khz,
  input  logic                    enable,
  input  logic signed [VEL_W-1:0] velocity,
  input  logic                    load_valid,
  input  logic signed [POS_W-1:0] load_pos,
  output logic                    tick,
  output logic signed [POS_W-1:0] position,
  output logic                    quad_a,
  output logic                    quad_b,
`ifdef SIM_ENC_INDEX_EN
  output logic                    index,
`endif
  output logic                    wrap
);

  if (VEL_W > ACC_W || IDX_SHIFT < 1 || IDX_SHIFT > POS_W) begin : g_bad_params
    $error("sim_quad_encoder: VEL_W must not exceed ACC_W and IDX_SHIFT must lie in 1..POS_W");
  end

  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic             tick_q, tick_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             quad_a_q, quad_a_d;
  logic             quad_b_q, quad_b_d;
  logic             wrap_q, wrap_d;
`ifdef SIM_ENC_INDEX_EN
  logic             index_q, index_d;
`endif

  logic                    tick_int;
  logic signed [ACC_W-1:0] vel_ext;
  logic [ACC_W:0]          sum;
  logic                    carry;
  logic                    step_up;
  logic                    step_dn;

  always_comb begin
    tick_int = sync2_q & ~prev_q;
    vel_ext  = ACC_W'(velocity);
    sum      = {1'b0, acc_q} + {1'b0, vel_ext};
    carry    = sum[ACC_W];
    // A negative increment is an add of its two's complement: no carry out means a borrow.
    step_up  = ~velocity[VEL_W-1] & carry;
    step_dn  =  velocity[VEL_W-1] & ~carry;

    sync1_d    = clk_200khz;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    tick_d     = tick_int;
    acc_d      = acc_q;
    position_d = position_q;
    wrap_d     = wrap_q;

    if (load_valid) begin
      position_d = load_pos;
      acc_d      = '0;
      wrap_d     = 1'b0;
    end else if (tick_int && enable) begin
      acc_d = sum[ACC_W-1:0];
      if (step_up) begin
        position_d = position_q + POS_W'(1);
        if (position_q == POS_MAX) wrap_d = 1'b1;
      end else if (step_dn) begin
        position_d = position_q - POS_W'(1);
        if (position_q == POS_MIN) wrap_d = 1'b1;
      end
    end

    quad_a_d = position_d[1];
    quad_b_d = position_d[1] ^ position_d[0];
`ifdef SIM_ENC_INDEX_EN
    index_d  = (position_d[IDX_SHIFT-1:0] == '0);
`endif
  end

  always_ff @(posedge clk_50Mhz) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      tick_q     <= 1'b0;
      acc_q      <= '0;
      position_q <= '0;
      quad_a_q   <= 1'b0;
      quad_b_q   <= 1'b0;
      wrap_q     <= 1'b0;
`ifdef SIM_ENC_INDEX_EN
      index_q    <= 1'b1;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      tick_q     <= tick_d;
      acc_q      <= acc_d;
      position_q <= position_d;
      quad_a_q   <= quad_a_d;
      quad_b_q   <= quad_b_d;
      wrap_q     <= wrap_d;
`ifdef SIM_ENC_INDEX_EN
      index_q    <= index_d;
`endif
    end
  end

  assign tick     = tick_q;
  assign position = position_q;
  assign quad_a   = quad_a_q;
  assign quad_b   = quad_b_q;
  assign wrap     = wrap_q;
`ifdef SIM_ENC_INDEX_EN
  assign index    = index_q;
`endif

endmodule
